// File: rtl/swept_pulse_mask.sv
`default_nettype none
// ============================================================================
// Module   : swept_pulse_mask
// Brief    : Multi-channel duty/offset pulse masks on a shared period counter
//            with optional linear period sweep (enabled by SWEPT_PULSE_SWEEP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module swept_pulse_mask #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int DATA_W = 16,
   parameter logic signed [DATA_W-1:0] MASK_HI = 16'sh7FFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     restart,
   input  logic                     enable,
   input  logic [CNT_W-1:0]         p_start,
   input  logic [CNT_W-1:0]         p_stop,
   input  logic [CNT_W-1:0]         p_step,
   input  logic [1:0]               sweep_mode,
   input  logic [NUM_CH*CNT_W-1:0]  duty,
   input  logic [NUM_CH*CNT_W-1:0]  offset,
   input  logic [NUM_CH*DATA_W-1:0] passthrough,
   output logic [NUM_CH*DATA_W-1:0] final_out,
   output logic [NUM_CH*DATA_W-1:0] mask_dac,
   output logic [NUM_CH-1:0]        mask_dio,
   output logic [CNT_W-1:0]         period_now,
   output logic                     period_stb,
   output logic                     sweep_done
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t                    r_state, w_state_nxt;
   logic [CNT_W-1:0]          r_cnt, r_period;
   logic                      r_fwd;
   logic [NUM_CH*CNT_W-1:0]   r_duty, r_offset;
   logic                      r_stb;
   logic [NUM_CH-1:0]         r_mask;
   logic [NUM_CH*DATA_W-1:0]  r_final, r_dac;

   logic                      w_enter, w_wrap, w_keep;
   logic [CNT_W-1:0]          w_period_nxt;
   logic                      w_fwd_nxt, w_done_hit;
   logic [NUM_CH-1:0]         w_mask;

`ifdef SWEPT_PULSE_SWEEP_EN
   // One step from cur toward tgt, never passing it.
   function automatic logic [CNT_W:0] f_toward(input logic [CNT_W:0] cur,
                                               input logic [CNT_W:0] tgt,
                                               input logic [CNT_W:0] stp,
                                               input logic           inc);
      logic [CNT_W:0] sum;
      sum = cur + stp;
      if (inc) f_toward = (sum > tgt) ? tgt : sum;
      else     f_toward = (cur < tgt + stp) ? tgt : cur - stp;
   endfunction

   logic [CNT_W:0] w_cur, w_start, w_stop, w_stp, w_tgt, w_alt, w_nx;
   logic           w_inc, w_reached;
   logic           w_unused_msb;

   // r_fwd: heading toward p_stop (1) or back toward p_start (0)
   always_comb begin
      w_cur      = {1'b0, r_period};
      w_start    = {1'b0, p_start};
      w_stop     = {1'b0, p_stop};
      w_stp      = {1'b0, p_step};
      w_inc      = ((p_stop >= p_start) == r_fwd);
      w_tgt      = r_fwd ? w_stop : w_start;
      w_alt      = r_fwd ? w_start : w_stop;
      w_reached  = w_inc ? (w_cur >= w_tgt) : (w_cur <= w_tgt);
      w_nx       = w_cur;
      w_fwd_nxt  = r_fwd;
      w_done_hit = 1'b0;
      if (p_step == '0) begin
         w_nx      = w_start;
         w_fwd_nxt = 1'b1;
      end else if (!w_reached) begin
         w_nx = f_toward(w_cur, w_tgt, w_stp, w_inc);
      end else begin
         case (sweep_mode)
            2'd1: begin
               w_nx      = w_start;
               w_fwd_nxt = 1'b1;
            end
            2'd2: begin
               w_nx      = f_toward(w_cur, w_alt, w_stp, !w_inc);
               w_fwd_nxt = !r_fwd;
            end
            default: begin
               w_done_hit = r_fwd;
               if (!r_fwd) begin
                  w_nx      = f_toward(w_cur, w_alt, w_stp, !w_inc);
                  w_fwd_nxt = 1'b1;
               end
            end
         endcase
      end
      if (w_nx == '0) w_nx = (CNT_W+1)'(1);
   end

   assign w_period_nxt = w_nx[CNT_W-1:0];
   assign w_unused_msb = w_nx[CNT_W];
   assign sweep_done   = (r_state == S_DONE);
`else
   logic w_unused_cfg;
   assign w_period_nxt = p_start;
   assign w_fwd_nxt    = 1'b1;
   assign w_done_hit   = 1'b0;
   assign w_unused_cfg = ^{p_stop, p_step, sweep_mode, r_fwd};
   assign sweep_done   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enter     = 1'b0;
      w_wrap      = 1'b0;
      if (!enable || p_start == '0) begin
         w_state_nxt = S_IDLE;
      end else if (restart || r_state == S_IDLE) begin
         w_enter     = 1'b1;
         w_state_nxt = S_RUN;
      end else begin
         w_wrap = (r_cnt >= r_period - CNT_W'(1));
         if (w_wrap && r_state == S_RUN && w_done_hit) w_state_nxt = S_DONE;
      end
   end

   assign w_keep = (w_state_nxt != S_IDLE);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] w_duty_i, w_off_m, w_phase;
      assign w_duty_i = r_duty[i*CNT_W +: CNT_W];
      assign w_off_m  = (r_period == '0) ? '0 : r_offset[i*CNT_W +: CNT_W] % r_period;
      assign w_phase  = (r_cnt >= w_off_m) ? (r_cnt - w_off_m)
                                           : (r_cnt + (r_period - w_off_m));
      assign w_mask[i] = (r_state != S_IDLE) && (w_duty_i != '0) && (w_phase < w_duty_i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_period <= '0;
         r_fwd    <= 1'b1;
         r_duty   <= '0;
         r_offset <= '0;
         r_stb    <= 1'b0;
         r_mask   <= '0;
         r_final  <= '0;
         r_dac    <= '0;
      end else begin
         r_stb <= 1'b0;
         if (w_state_nxt == S_IDLE) begin
            r_cnt <= '0;
         end else if (w_enter) begin
            r_cnt    <= '0;
            r_period <= p_start;
            r_fwd    <= 1'b1;
            r_duty   <= duty;
            r_offset <= offset;
         end else if (w_wrap) begin
            r_cnt    <= '0;
            r_stb    <= 1'b1;
            r_duty   <= duty;
            r_offset <= offset;
            if (r_state == S_RUN) begin
               r_period <= w_period_nxt;
               r_fwd    <= w_fwd_nxt;
            end
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         r_mask <= w_mask & {NUM_CH{w_keep}};
         for (int i = 0; i < NUM_CH; i++) begin
            r_final[i*DATA_W +: DATA_W] <= (w_mask[i] && w_keep) ? passthrough[i*DATA_W +: DATA_W] : '0;
            r_dac[i*DATA_W +: DATA_W]   <= (w_mask[i] && w_keep) ? MASK_HI : '0;
         end
      end
   end

   assign final_out  = r_final;
   assign mask_dac   = r_dac;
   assign mask_dio   = r_mask;
   assign period_now = r_period;
   assign period_stb = r_stb;

endmodule
`default_nettype wire

// File: tb/tb_swept_pulse_mask.sv
`default_nettype none
// ============================================================================
// Module   : tb_swept_pulse_mask
// Brief    : Directed self-checking bench for swept_pulse_mask (2 channels).
// Revision : 1.0 - initial release
// ============================================================================
module tb_swept_pulse_mask;

   logic        clk = 1'b0;
   logic        reset, restart, enable;
   logic [31:0] p_start, p_stop, p_step;
   logic [1:0]  sweep_mode;
   logic [63:0] duty, offset;
   logic [31:0] passthrough, final_out, mask_dac;
   logic [1:0]  mask_dio;
   logic [31:0] period_now;
   logic        period_stb, sweep_done;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned exp_p[8];
   int          exp_done_idx;
   logic [15:0] pt0, pt1;
   logic        m0;

   always #5 clk = ~clk;

   swept_pulse_mask dut (
      .clk(clk), .reset(reset), .restart(restart), .enable(enable),
      .p_start(p_start), .p_stop(p_stop), .p_step(p_step), .sweep_mode(sweep_mode),
      .duty(duty), .offset(offset), .passthrough(passthrough),
      .final_out(final_out), .mask_dac(mask_dac), .mask_dio(mask_dio),
      .period_now(period_now), .period_stb(period_stb), .sweep_done(sweep_done)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, " final"}, final_out, 0);
      check_val({tag, " dac"}, mask_dac, 0);
      check_val({tag, " dio"}, mask_dio, 0);
      check_val({tag, " stb"}, period_stb, 0);
   endtask

   task automatic start_run(input logic [31:0] s, input logic [31:0] e,
                            input logic [31:0] st, input logic [1:0] m);
      @(negedge clk); enable = 1'b0;
      @(negedge clk);
      p_start = s; p_stop = e; p_step = st; sweep_mode = m; enable = 1'b1;
      @(negedge clk);
      check_val("entry period", period_now, s);
      check_val("entry done", sweep_done, 0);
   endtask

   task automatic run_seq(input string tag, input int n);
      int seen = 0;
      for (int c = 0; c < 200 && seen < n; c++) begin
         @(negedge clk);
         if (period_stb) begin
            check_val({tag, " period"}, period_now, exp_p[seen]);
            check_val({tag, " done"}, sweep_done, (seen >= exp_done_idx));
            seen++;
         end
      end
      check_val({tag, " stb count"}, seen, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; restart = 1'b0; enable = 1'b0;
      p_start = 0; p_stop = 0; p_step = 0; sweep_mode = 0;
      duty = 0; offset = 0; passthrough = 0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check_val("reset period", period_now, 0);
      check_val("reset done", sweep_done, 0);

      // Fixed period 10, ch0 duty 3, ch1 duty 20 with offset 12 (always high)
      p_start = 10; duty = {32'd20, 32'd3}; offset = {32'd12, 32'd0};
      reset = 1'b1; enable = 1'b1;
      for (int k = 0; k < 30; k++) begin
         pt0 = 16'(100 + k); pt1 = 16'(16'h8000 + k * 7);
         passthrough = {pt1, pt0};
         @(negedge clk);
         m0 = (k > 0) && (((k - 1) % 10) < 3);
         check_val("t1 mask0", mask_dio[0], m0);
         check_val("t1 stb", period_stb, (k > 0 && k % 10 == 0));
         check_val("t1 dac0", mask_dac[15:0], m0 ? 16'h7fff : 16'h0);
         check_val("t1 fin0", final_out[15:0], m0 ? pt0 : 16'h0);
         check_val("t1 period", period_now, 10);
         check_val("t4 mask1", mask_dio[1], (k > 0));
         check_val("t4 fin1", final_out[31:16], (k > 0) ? pt1 : 16'h0);
      end

      // Restart mid-period (cnt=3) with a new start period of 12
      repeat (4) @(negedge clk);
      restart = 1'b1; p_start = 12;
      @(negedge clk);
      restart = 1'b0;
      check_val("rs period", period_now, 12);
      check_val("rs mask0", mask_dio[0], 0);
      check_val("rs stb", period_stb, 0);
      for (int j = 1; j <= 14; j++) begin
         @(negedge clk);
         check_val("rs mask0 run", mask_dio[0], (((j - 1) % 12) < 3));
         check_val("rs stb run", period_stb, (j == 12));
      end

      // Disable while ch0 would be high
      enable = 1'b0;
      @(negedge clk);
      check_idle("dis");
      @(negedge clk);
      check_idle("dis2");

      // Enabled with p_start=0 stays idle
      p_start = 0; enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_idle("pstart0");
      end

      // Offset 13 on period 10 -> high at cnt 3..5; ch1 duty 0 never high
      p_start = 10; duty = {32'd0, 32'd3}; offset = {32'd0, 32'd13};
      passthrough = 32'h1234_5678;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         m0 = (k > 0) && (((k - 1) % 10) >= 3) && (((k - 1) % 10) <= 5);
         check_val("off mask0", mask_dio[0], m0);
         check_val("off fin0", final_out[15:0], m0 ? 16'h5678 : 16'h0);
         check_val("off mask1", mask_dio[1], 0);
         check_val("off fin1", final_out[31:16], 0);
      end

      // Asynchronous reset between clock edges
      #2 reset = 1'b0;
      #1;
      check_idle("areset");
      check_val("areset period", period_now, 0);
      check_val("areset done", sweep_done, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         m0 = (k > 0) && (((k - 1) % 10) >= 3) && (((k - 1) % 10) <= 5);
         check_val("rel period", period_now, 10);
         check_val("rel mask0", mask_dio[0], m0);
      end

`ifdef SWEPT_PULSE_SWEEP_EN
      exp_p[0] = 6; exp_p[1] = 8; exp_p[2] = 8; exp_p[3] = 8;
      exp_done_idx = 2;
`else
      for (int i = 0; i < 8; i++) exp_p[i] = 4;
      exp_done_idx = 99;
`endif
      start_run(4, 8, 2, 2'd0);
      run_seq("oneshot", 4);

`ifdef SWEPT_PULSE_SWEEP_EN
      exp_p[0] = 6; exp_p[1] = 7; exp_p[2] = 5; exp_p[3] = 4; exp_p[4] = 6; exp_p[5] = 7;
`endif
      exp_done_idx = 99;
      start_run(4, 7, 2, 2'd2);
      run_seq("triangle", 6);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
